// File: rtl/dcache_responder_if.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_responder_if
//  Purpose  : Bundles the CPU-side request/response bus and the line-level
//             physical-memory bus of the data cache responder.
//  Modports : master - pipeline MEM stage (drives requests, takes responses)
//             slave  - cache (serves CPU requests, masters the pmem bus)
//             memory - physical memory / arbiter side of the line bus
//  Revision : 1.0  initial release
// ============================================================================
interface dcache_responder_if;
    // CPU side
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    // Physical-memory side
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  mem_rdata, mem_resp
    );

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport memory (
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface
`default_nettype wire

// File: rtl/dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dcache_responder
//  Purpose  : Direct-mapped, write-back, write-allocate data cache with
//             32-byte lines. Hits respond combinationally in IDLE; misses
//             write back a dirty victim (if any) and then fill the line from
//             a 256-bit physical-memory port.
//  Ports    : clk  - clock, rising edge
//             rst  - asynchronous reset, active low
//             bus  - dcache_responder_if.slave (CPU bus + pmem line bus)
//  Revision : 1.0  initial release
// ============================================================================
module dcache_responder #(
    parameter int S_INDEX = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dcache_responder_if.slave bus
);
    localparam int SETS  = 2 ** S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    localparam logic [1:0] C_IDLE      = 2'd0;
    localparam logic [1:0] C_WRITEBACK = 2'd1;
    localparam logic [1:0] C_FILL      = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [SETS-1:0]    r_valid;
    logic [SETS-1:0]    r_dirty;
    logic [TAG_W-1:0]   r_tag  [SETS];
    logic [255:0]       r_data [SETS];

    logic [S_INDEX-1:0] w_idx;
    logic [TAG_W-1:0]   w_addr_tag;
    logic [2:0]         w_word;
    logic [7:0]         w_bitbase;
    logic [255:0]       w_line;
    logic [255:0]       w_merged;
    logic               w_req;
    logic               w_hit;
    logic               w_hit_write;
    logic               w_wb_done;
    logic               w_fill_done;
    logic               w_unused;

    // Address decomposition; byte offset [1:0] is not needed for word access
    assign w_word     = bus.mem_address[4:2];
    assign w_idx      = bus.mem_address[5 +: S_INDEX];
    assign w_addr_tag = bus.mem_address[31 -: TAG_W];
    assign w_bitbase  = {w_word, 5'b0};
    assign w_unused   = ^bus.mem_address[1:0];

    assign w_line = r_data[w_idx];
    assign w_req  = bus.mem_read | bus.mem_write;
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_addr_tag);

    // A simultaneous read and write is served as a write
    assign w_hit_write = (r_state == C_IDLE) && bus.mem_write && w_hit;
    assign w_wb_done   = (r_state == C_WRITEBACK) && bus.pmem_resp;
    assign w_fill_done = (r_state == C_FILL) && bus.pmem_resp;

    // Outputs
    assign bus.mem_resp     = (r_state == C_IDLE) && w_req && w_hit;
    assign bus.mem_rdata    = w_line[w_bitbase +: 32];
    assign bus.pmem_write   = (r_state == C_WRITEBACK);
    assign bus.pmem_read    = (r_state == C_FILL);
    assign bus.pmem_wdata   = w_line;
    assign bus.pmem_address = (r_state == C_WRITEBACK) ? {r_tag[w_idx], w_idx, 5'b0}
                                                       : {bus.mem_address[31:5], 5'b0};

    // Byte-lane merge of the CPU write into the indexed line
    always_comb begin
        w_merged = w_line;
        for (int b = 0; b < 4; b++) begin
            if (bus.mem_byte_enable[b]) begin
                w_merged[w_bitbase + 8'(8 * b) +: 8] = bus.mem_wdata[8 * b +: 8];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: begin
                if (w_req && !w_hit) begin
                    w_state_next = (r_valid[w_idx] && r_dirty[w_idx]) ? C_WRITEBACK : C_FILL;
                end
            end
            C_WRITEBACK: if (bus.pmem_resp) w_state_next = C_FILL;
            C_FILL:      if (bus.pmem_resp) w_state_next = C_IDLE;
            default:     w_state_next = C_IDLE;
        endcase
    end

    // Control state: the only storage cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= C_IDLE;
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_fill_done) begin
                r_valid[w_idx] <= 1'b1;
                r_dirty[w_idx] <= 1'b0;
            end else if (w_wb_done) begin
                r_dirty[w_idx] <= 1'b0;
            end else if (w_hit_write) begin
                // Set even when no byte lane is enabled
                r_dirty[w_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits qualify them
    always_ff @(posedge clk) begin
        if (w_fill_done) begin
            r_data[w_idx] <= bus.pmem_rdata;
            r_tag[w_idx]  <= w_addr_tag;
        end else if (w_hit_write) begin
            r_data[w_idx] <= w_merged;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_dcache_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dcache_responder
//  Purpose  : Self-checking bench for dcache_responder. A word-level golden
//             model holds the CPU-visible memory image, a separate backing
//             store plays physical memory; read expectations are queued when
//             a request is driven and popped when mem_resp appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dcache_responder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dcache_responder_if bus ();

    dcache_responder #(.S_INDEX(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] gold [logic [31:0]];
    logic [31:0] bkw  [logic [31:0]];
    logic [31:0] exp_q [$];

    // Results of the most recent access
    int          lat, n_wb, n_fill, unstable;
    logic [31:0] wb_addr, fill_addr, rdata;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hC3C3_0000;
    endfunction

    function automatic logic [31:0] gold_rd(input logic [31:0] a);
        logic [31:0] a2 = {a[31:2], 2'b00};
        return gold.exists(a2) ? gold[a2] : dflt(a2);
    endfunction

    function automatic logic [31:0] bk_rd(input logic [31:0] a);
        logic [31:0] a2 = {a[31:2], 2'b00};
        return bkw.exists(a2) ? bkw[a2] : dflt(a2);
    endfunction

    task automatic gold_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] w = gold_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) w[8 * b +: 8] = d[8 * b +: 8];
        gold[{a[31:2], 2'b00}] = w;
    endtask

    function automatic logic [255:0] gold_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32 * i +: 32] = gold_rd(la + 32'(4 * i));
        return l;
    endfunction

    function automatic logic [255:0] bk_line(input logic [31:0] la);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[32 * i +: 32] = bk_rd(la + 32'(4 * i));
        return l;
    endfunction

    task automatic bk_store(input logic [31:0] la, input logic [255:0] l);
        for (int i = 0; i < 8; i++) bkw[la + 32'(4 * i)] = l[32 * i +: 32];
    endtask

    task automatic seed(input logic [31:0] a, input logic [31:0] v);
        gold[a] = v;
        bkw[a]  = v;
    endtask

    // Drive one request and act as physical memory until mem_resp.
    // Entered and left at posedge+1.
    task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] be, input int wb_lat, input int fill_lat);
        int  pc   = 0;
        bit  done = 0;
        logic [31:0] e;
        bus.mem_read        = !wr;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_wdata       = wd;
        bus.mem_byte_enable = be;
        if (!wr) exp_q.push_back(gold_rd(addr));
        else     gold_wr(addr, wd, be);
        lat = -1; n_wb = 0; n_fill = 0; unstable = 0;
        wb_addr = '0; fill_addr = '0; rdata = '0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (bus.pmem_read && bus.pmem_write) unstable++;
            if (bus.mem_resp) begin
                lat  = n;
                done = 1;
                if (!wr) begin
                    e     = exp_q.pop_front();
                    rdata = bus.mem_rdata;
                    chk("sb_rdata", bus.mem_rdata, e);
                end
            end else if (bus.pmem_write) begin
                if (pc == 0) wb_addr = bus.pmem_address;
                else if (bus.pmem_address !== wb_addr) unstable++;
                pc++;
                if (pc == wb_lat) begin
                    chk("wb_data", bus.pmem_wdata, gold_line(wb_addr));
                    bk_store(wb_addr, bus.pmem_wdata);
                    bus.pmem_resp = 1'b1;
                    pc = 0;
                    n_wb++;
                end
            end else if (bus.pmem_read) begin
                if (pc == 0) fill_addr = bus.pmem_address;
                else if (bus.pmem_address !== fill_addr) unstable++;
                pc++;
                if (pc == fill_lat) begin
                    bus.pmem_rdata = bk_line(fill_addr);
                    bus.pmem_resp  = 1'b1;
                    pc = 0;
                    n_fill++;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.pmem_resp = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        chk("resp_seen", 256'(done), 256'd1);
    endtask

    initial begin
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = '0;
        bus.mem_wdata = '0; bus.mem_byte_enable = '0;
        bus.pmem_rdata = '0; bus.pmem_resp = 0;
        seed(32'h0000_0044, 32'hAAAA_AAAA);
        seed(32'h0000_0048, 32'hDEAD_BEEF);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_resp",   256'(bus.mem_resp),   256'd0);
        chk("rst_pmem_read",  256'(bus.pmem_read),  256'd0);
        chk("rst_pmem_write", 256'(bus.pmem_write), 256'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Clean miss fill
        access(0, 32'h0000_0048, '0, '0, 1, 1);
        chk("t1_lat",    256'(lat),       256'd2);
        chk("t1_fill_a", 256'(fill_addr), 256'h40);
        chk("t1_nwb",    256'(n_wb),      256'd0);
        chk("t1_rdata",  256'(rdata),     256'hDEAD_BEEF);

        // Partial write hit, then read back
        access(1, 32'h0000_0044, 32'h1234_5678, 4'b0011, 1, 1);
        chk("t2_wr_lat", 256'(lat), 256'd0);
        access(0, 32'h0000_0044, '0, '0, 1, 1);
        chk("t2_rdata",  256'(rdata), 256'hAAAA_5678);

        // Dirty victim at set 2
        access(0, 32'h0000_1040, '0, '0, 2, 3);
        chk("t3_lat",    256'(lat),       256'd6);
        chk("t3_nwb",    256'(n_wb),      256'd1);
        chk("t3_wb_a",   256'(wb_addr),   256'h40);
        chk("t3_fill_a", 256'(fill_addr), 256'h1040);

        // Dirty the new line, then stall its writeback for 20 cycles
        access(1, 32'h0000_1048, 32'h0F0F_0F0F, 4'b1111, 1, 1);
        chk("t6_wr_lat", 256'(lat), 256'd0);
        access(0, 32'h0000_0040, '0, '0, 20, 1);
        chk("t6_lat",      256'(lat),      256'd22);
        chk("t6_wb_a",     256'(wb_addr),  256'h1040);
        chk("t6_unstable", 256'(unstable), 256'd0);

        // Back-to-back hits in consecutive cycles
        access(0, 32'h0000_0040, '0, '0, 1, 1);
        chk("t5_lat0", 256'(lat + n_wb + n_fill), 256'd0);
        access(0, 32'h0000_0048, '0, '0, 1, 1);
        chk("t5_lat1", 256'(lat + n_wb + n_fill), 256'd0);
        chk("t5_rdata", 256'(rdata), 256'hDEAD_BEEF);
        access(0, 32'h0000_005C, '0, '0, 1, 1);
        chk("t5_lat2", 256'(lat + n_wb + n_fill), 256'd0);

        // Empty byte enable still dirties the line
        access(1, 32'h0000_0044, 32'hFFFF_FFFF, 4'b0000, 1, 1);
        chk("be0_lat", 256'(lat), 256'd0);
        access(0, 32'h0000_1044, '0, '0, 1, 1);
        chk("be0_nwb",  256'(n_wb),    256'd1);
        chk("be0_wb_a", 256'(wb_addr), 256'h40);
        chk("be0_lat2", 256'(lat),     256'd3);

        // Write-allocate miss
        access(1, 32'h0000_0084, 32'hCAFE_F00D, 4'b1111, 1, 2);
        chk("wmiss_lat", 256'(lat),  256'd3);
        chk("wmiss_nwb", 256'(n_wb), 256'd0);
        access(0, 32'h0000_0084, '0, '0, 1, 1);
        chk("wmiss_rd",  256'(rdata), 256'hCAFE_F00D);

        // Reset asserted in the middle of a fill
        bus.mem_read = 1'b1; bus.mem_address = 32'h0000_0200;
        for (int n = 0; n < 20 && !bus.pmem_read; n++) @(negedge clk);
        chk("t4_in_fill", 256'(bus.pmem_read), 256'd1);
        rst = 1'b0;
        #1;
        chk("t4_pmem_read",  256'(bus.pmem_read),  256'd0);
        chk("t4_pmem_write", 256'(bus.pmem_write), 256'd0);
        chk("t4_mem_resp",   256'(bus.mem_resp),   256'd0);
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        rst = 1'b1;
        access(0, 32'h0000_0200, '0, '0, 1, 1);
        chk("t4_remiss",  256'(lat),    256'd2);
        chk("t4_nfill",   256'(n_fill), 256'd1);
        access(0, 32'h0000_0048, '0, '0, 1, 1);
        chk("t4_inval",   256'(lat),    256'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
